// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in / parallel-out receiver.
package sipo_pkg;

    // Receiver word-assembly state: IDLE = no bits held, SHIFT = partial word held.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_e;

    // Bit-order encodings as seen on msb_first.
    localparam logic ORDER_LSB_FIRST = 1'b0;
    localparam logic ORDER_MSB_FIRST = 1'b1;

    localparam int SIPO_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sipo_shift_core.sv
// Direction-controlled shift register. shifted_o is the register value with
// the current bit already inserted, so the owner can capture a completed word
// on the same edge that the register clears.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_i,
    input  logic             clr_i,
    input  logic             msb_first_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] shifted_o
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;

    // MSB-first enters at bit 0 and moves up; LSB-first enters at the top and moves down.
    always_comb begin
        sreg_d = sreg_q;
        if (msb_first_i == ORDER_MSB_FIRST) begin
            sreg_d = {sreg_q[WIDTH-2:0], bit_i};
        end else begin
            sreg_d = {bit_i, sreg_q[WIDTH-1:1]};
        end
    end

    assign shifted_o = sreg_d;

    // Clear wins over shift; otherwise shift only on a strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg_q <= '0;
        end else if (clr_i) begin
            sreg_q <= '0;
        end else if (shift_i) begin
            sreg_q <= sreg_d;
        end
    end

endmodule

// File: rtl/sipo_receiver.sv
// Serial-to-parallel receiver with a one-deep valid/ready output register,
// sticky overrun flag and a sync input that drops any partial word.
module sipo_receiver
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             ser_en,
    input  logic             msb_first,
    input  logic             sync,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             ovr_clr,
    output logic             busy
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    sipo_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             order_q;
    logic             busy_q;

    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             ovr_q;

    logic             take_bit;
    logic             word_done;
    logic             cur_order;
    logic [WIDTH-1:0] word;

    // sync discards this cycle's bit; a word completes on the WIDTH-th sampled bit.
    assign take_bit  = ser_en & ~sync;
    assign word_done = take_bit & (state_q == SHIFT) & (cnt_q == LAST);
    // The first bit of a word uses the live order input; later bits the latched one.
    assign cur_order = (state_q == IDLE) ? msb_first : order_q;

    sipo_shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .shift_i    (take_bit),
        .clr_i      (sync | word_done),
        .msb_first_i(cur_order),
        .bit_i      (ser_in),
        .shifted_o  (word)
    );

    // Word-assembly FSM: bit counter, latched order and busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            order_q <= ORDER_LSB_FIRST;
            busy_q  <= 1'b0;
        end else if (sync) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (ser_en) begin
            case (state_q)
                IDLE: begin
                    order_q <= msb_first;
                    cnt_q   <= CNT_W'(1);
                    state_q <= SHIFT;
                    busy_q  <= 1'b1;
                end
                SHIFT: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output register: load when empty or being drained, else drop and flag overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (word_done) begin
                if (!valid_q || out_ready) begin
                    data_q  <= word;
                    valid_q <= 1'b1;
                end
            end else if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end
            // A new overrun in the same cycle as a clear keeps the flag set.
            if (word_done && valid_q && !out_ready) begin
                ovr_q <= 1'b1;
            end else if (ovr_clr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sipo_receiver.sv
// Directed bench for sipo_receiver (WIDTH=4). Inputs change on the falling
// edge and outputs are checked on the falling edge, away from the sampling edge.
module tb_sipo_receiver;

    logic       clk;
    logic       reset;
    logic       ser_in;
    logic       ser_en;
    logic       msb_first;
    logic       sync;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;
    logic       ovr_clr;
    logic       busy;

    int n_chk;
    int n_pass;

    sipo_receiver #(.WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .ser_in   (ser_in),
        .ser_en   (ser_en),
        .msb_first(msb_first),
        .sync     (sync),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun),
        .ovr_clr  (ovr_clr),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Present one strobed bit for one clock; entered and left at a falling edge.
    task automatic send(input logic b);
        ser_en = 1'b1;
        ser_in = b;
        @(negedge clk);
        ser_en = 1'b0;
        ser_in = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) send(w[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        reset     = 1'b1;
        ser_in    = 1'b0;
        ser_en    = 1'b0;
        msb_first = 1'b1;
        sync      = 1'b0;
        out_ready = 1'b1;
        ovr_clr   = 1'b0;
        idle(2);
        chk("rst_data",  out_data,  4'h0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ovr",   overrun,   1'b0);
        chk("rst_busy",  busy,      1'b0);
        reset = 1'b0;
        idle(1);

        // MSB order with a pause between bits: 1,0,(gap),1,1 -> 1011
        msb_first = 1'b1;
        send(1'b1); send(1'b0);
        idle(2);
        chk("msb_busy_gap", busy, 1'b1);
        send(1'b1);
        chk("msb_valid_pre", out_valid, 1'b0);
        send(1'b1);
        chk("msb_data",  out_data,  4'b1011);
        chk("msb_valid", out_valid, 1'b1);
        chk("msb_busy",  busy,      1'b0);
        idle(1);
        chk("msb_valid_1cyc", out_valid, 1'b0);

        // LSB order: 1,0,1,1 -> 1101
        msb_first = 1'b0;
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        chk("lsb_data",  out_data,  4'b1101);
        chk("lsb_valid", out_valid, 1'b1);
        idle(1);

        // LSB order with msb_first toggled mid-word: still 1101
        msb_first = 1'b0;
        send(1'b1); send(1'b0);
        msb_first = 1'b1;
        send(1'b1); send(1'b1);
        chk("lsb_tog_data", out_data, 4'b1101);
        idle(1);
        chk("lsb_tog_drain", out_valid, 1'b0);

        // Overrun: 0xA held, 0x5 dropped
        msb_first = 1'b1;
        out_ready = 1'b0;
        send_word(4'hA);
        chk("ovr_first", out_data, 4'hA);
        send_word(4'h5);
        chk("ovr_data",  out_data,  4'hA);
        chk("ovr_flag",  overrun,   1'b1);
        chk("ovr_valid", out_valid, 1'b1);
        ovr_clr = 1'b1;
        idle(1);
        ovr_clr = 1'b0;
        chk("ovr_clr", overrun, 1'b0);
        // Set beats clear in the same cycle
        send(1'b0); send(1'b0); send(1'b1);
        ovr_clr = 1'b1;
        send(1'b1);
        ovr_clr = 1'b0;
        chk("ovr_set_wins", overrun, 1'b1);
        chk("ovr_data2",    out_data, 4'hA);
        ovr_clr = 1'b1;
        out_ready = 1'b1;
        idle(1);
        ovr_clr = 1'b0;
        chk("ovr_drain", out_valid, 1'b0);
        chk("ovr_clr2",  overrun,   1'b0);

        // Sync: word 0x9 held, partial word aborted, then 0,1,1,0 -> 6
        out_ready = 1'b0;
        send_word(4'h9);
        send(1'b1); send(1'b1);
        chk("sync_busy_pre", busy, 1'b1);
        sync = 1'b1; ser_en = 1'b1; ser_in = 1'b1;
        idle(1);
        sync = 1'b0; ser_en = 1'b0; ser_in = 1'b0;
        chk("sync_busy",  busy,      1'b0);
        chk("sync_valid", out_valid, 1'b1);
        chk("sync_data",  out_data,  4'h9);
        chk("sync_ovr",   overrun,   1'b0);
        out_ready = 1'b1;
        idle(1);
        send(1'b0); send(1'b1); send(1'b1); send(1'b0);
        chk("sync_word", out_data, 4'h6);
        idle(1);

        // Async reset mid-word, with valid data and overrun set beforehand
        out_ready = 1'b0;
        send_word(4'h5);
        send_word(4'h3);
        send(1'b1); send(1'b1); send(1'b0);
        chk("rmw_ovr_pre", overrun, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("rmw_data",  out_data,  4'h0);
        chk("rmw_valid", out_valid, 1'b0);
        chk("rmw_ovr",   overrun,   1'b0);
        chk("rmw_busy",  busy,      1'b0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        send(1'b1); send(1'b1); send(1'b1); send(1'b1);
        chk("rmw_word", out_data, 4'hF);
        idle(1);

        // Back-to-back: 0x3 accepted on the edge 0xC completes
        out_ready = 1'b0;
        send_word(4'h3);
        chk("b2b_first", out_data, 4'h3);
        send(1'b1); send(1'b1); send(1'b0);
        out_ready = 1'b1;
        send(1'b0);
        out_ready = 1'b0;
        chk("b2b_valid", out_valid, 1'b1);
        chk("b2b_data",  out_data,  4'hC);
        chk("b2b_ovr",   overrun,   1'b0);
        out_ready = 1'b1;
        idle(1);
        chk("b2b_drain", out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sipo_receiver.md
SIPO_RECEIVER -- requirements
Module: sipo_receiver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (minimum 2).
REQ-002 Port clk  input  1  rising-edge clock.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port ser_in  input  1  serial data bit.
REQ-005 Port ser_en  input  1  bit strobe; ser_in is sampled on a clk edge where ser_en=1.
REQ-006 Port msb_first  input  1  bit order: 1 = first received bit ends in MSB; 0 = first received bit ends in LSB.
REQ-007 Port sync  input  1  aborts any partial word and restarts bit alignment.
REQ-008 Port out_data  output  WIDTH  completed parallel word.
REQ-009 Port out_valid  output  1  out_data holds an unconsumed word.
REQ-010 Port out_ready  input  1  consumer accepts out_data when out_valid=1 and out_ready=1.
REQ-011 Port overrun  output  1  sticky flag: a completed word was dropped.
REQ-012 Port ovr_clr  input  1  clears overrun.
REQ-013 Port busy  output  1  a partial word (1..WIDTH-1 bits) is held.

Function
REQ-014 The block SHALL have two states: IDLE (bit count 0) and SHIFT (bit count 1..WIDTH-1); busy=1 exactly in SHIFT.
REQ-015 In IDLE, ser_en=1 SHALL capture the first bit, latch msb_first as the word order, and go to SHIFT.
REQ-016 Changes on msb_first while in SHIFT SHALL be ignored until the next word starts.
REQ-017 With order MSB-first, each sampled bit SHALL shift in at bit 0 and existing bits move toward the MSB.
REQ-018 With order LSB-first, each sampled bit SHALL shift in at bit WIDTH-1 and existing bits move toward bit 0.
REQ-019 On the edge sampling the WIDTH-th bit, the word SHALL complete, the state SHALL return to IDLE, and the shift register SHALL clear.
REQ-020 Cycles with ser_en=0 SHALL hold state, count and shift register unchanged.
REQ-021 A completed word SHALL load out_data and set out_valid on the same edge that samples the WIDTH-th bit, so out_valid is visible in the following cycle.
REQ-022 The completed word SHALL load only if out_valid=0, or if out_valid=1 and out_ready=1 in that cycle. In the second case out_valid stays 1 and carries the new data.
REQ-023 If out_valid=1 and out_ready=0 when a word completes, the new word SHALL be discarded, out_data SHALL keep its value, and overrun SHALL be set to 1.
REQ-024 out_valid=1 with out_ready=1 and no word completing SHALL clear out_valid on that edge.
REQ-025 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 sync=1 SHALL have priority over ser_en: bit count goes to 0, the shift register clears, the state goes to IDLE, and that cycle's ser_in is discarded.
REQ-027 sync SHALL NOT alter out_data, out_valid or overrun.
REQ-028 ovr_clr=1 SHALL clear overrun; if an overrun event occurs in the same cycle, set SHALL win.

Reset
REQ-029 reset=1 SHALL asynchronously force the following, regardless of clk: state IDLE, bit count 0, shift register 0, out_data 0, out_valid 0, overrun 0, busy 0.
REQ-030 After reset is released, the first sampled bit SHALL start a fresh word.

Structure
REQ-031 A shared package sipo_pkg SHALL hold the state enum (IDLE, SHIFT), the order constants ORDER_LSB_FIRST=0 and ORDER_MSB_FIRST=1, and the default WIDTH.
REQ-032 The bit counter width SHALL be $clog2(WIDTH) and SHALL compare against WIDTH-1 for completion.
REQ-033 One sub-module, sipo_shift_core, SHALL contain the direction-controlled shift register and its clear; the handshake, counter and FSM SHALL stay in sipo_receiver.

Verification (WIDTH=4)
REQ-034 MSB order: msb_first=1, out_ready=1, ser_en=1, bits 1,0,1,1 -> out_data=4'b1011 and out_valid=1 for exactly one cycle, starting the cycle after the 4th bit.
REQ-035 LSB order: msb_first=0, bits 1,0,1,1 -> out_data=4'b1101; toggling msb_first after bit 2 gives the same result.
REQ-036 Overrun: out_ready=0, send 0xA then 0x5 -> out_data stays 0xA and overrun=1; pulse ovr_clr -> overrun=0; out_ready=1 -> out_valid drops.
REQ-037 Sync: send 2 bits, pulse sync, then send 0,1,1,0 with MSB order -> out_data=4'h6, busy=0 after sync, and out_valid unaffected by the sync pulse.
REQ-038 Reset mid-word: assert reset asynchronously after 3 bits -> all outputs 0 immediately; the next 4 bits 1,1,1,1 give out_data=4'hF.
REQ-039 Back-to-back: consumer accepts 0x3 in the same cycle that 0xC completes -> out_valid stays 1, out_data=0xC, overrun=0.
